// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the EX-stage multiply/divide initiator.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  function automatic logic is_muldiv(input op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO pair; a core result write wins over a move write.
module muldiv_ctrl_hilo_regs #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_res_we,
  input  logic [DATA_W-1:0] i_res_hi,
  input  logic [DATA_W-1:0] i_res_lo,
  input  logic              i_mthi_we,
  input  logic              i_mtlo_we,
  input  logic [DATA_W-1:0] i_mv_data,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi, r_lo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_res_we) begin
      r_hi <= i_res_hi;
      r_lo <= i_res_lo;
    end else begin
      if (i_mthi_we) r_hi <= i_mv_data;
      if (i_mtlo_we) r_lo <= i_mv_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage launcher for the multi-cycle mul/div core: latches operands,
// runs the start/done handshake, stalls EX meanwhile and commits HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LAT = 72,
  parameter int CNT_W   = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  op_t               i_ex_op,
  input  logic [DATA_W-1:0] i_ex_src_a,
  input  logic [DATA_W-1:0] i_ex_src_b,
  input  logic              i_pipe_stall,
  input  logic              i_flush,
  output logic              o_ex_stall,
  output logic              o_core_start,
  output logic              o_core_abort,
  output logic              o_core_div,
  output logic              o_core_sign,
  output logic [DATA_W-1:0] o_core_a,
  output logic [DATA_W-1:0] o_core_b,
  input  logic              i_core_done,
  input  logic [DATA_W-1:0] i_core_hi,
  input  logic [DATA_W-1:0] i_core_lo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_lat_err
);

  state_t            r_state;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_div, r_sign;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_lat_err;

  logic w_launch, w_mv, w_commit, w_busy;

  assign w_busy   = (r_state == S_START) || (r_state == S_WAIT);
  assign w_launch = i_ex_valid & ~i_flush & is_muldiv(i_ex_op);
  // Moves only retire from IDLE, and only once nothing else holds EX.
  assign w_mv     = (r_state == S_IDLE) & i_ex_valid & ~i_flush & ~i_pipe_stall;
  assign w_commit = (r_state == S_WAIT) & i_core_done & ~i_flush;

  assign o_ex_stall   = ((r_state == S_IDLE) & w_launch) | w_busy;
  assign o_core_start = (r_state == S_START);
  assign o_core_abort = w_busy & i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_div     <= 1'b0;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      r_lat_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_a     <= i_ex_src_a;
            r_b     <= i_ex_src_b;
            r_div   <= is_div(i_ex_op);
            r_sign  <= is_signed(i_ex_op);
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= i_flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (i_core_done) begin
            r_state <= S_HOLD;
          end else begin
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            // Counter hits MAX_LAT on this edge: the core is overdue.
            if (r_cnt == CNT_W'(MAX_LAT - 1)) r_lat_err <= 1'b1;
          end
        end
        S_HOLD: begin
          // Holding here while EX is stalled keeps the same op from relaunching.
          if (i_flush || !i_pipe_stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_core_a    = r_a;
  assign o_core_b    = r_b;
  assign o_core_div  = r_div;
  assign o_core_sign = r_sign;
  assign o_lat_err   = r_lat_err;

  muldiv_ctrl_hilo_regs #(.DATA_W(DATA_W)) u_hilo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_res_we  (w_commit),
    .i_res_hi  (i_core_hi),
    .i_res_lo  (i_core_lo),
    .i_mthi_we (w_mv & (i_ex_op == OP_MTHI)),
    .i_mtlo_we (w_mv & (i_ex_op == OP_MTLO)),
    .i_mv_data (i_ex_src_a),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

endmodule
